// File: rtl/ldpc_dvb_enc_sink_axs.sv
// DVB-S2 LDPC encoder output sink: prefetches buffer words through a credit FIFO and streams
// them as ready/valid beats. Optional macro LDPC_DVB_ENC_SINK_AXS_MSB_FIRST_EN selects MSB-first lanes.
module ldpc_dvb_enc_sink_axs #(
    parameter int pRADDR_W    = 8,
    parameter int pRDAT_W     = 32,
    parameter int pDAT_W      = 8,
    parameter int pTAG_W      = 8,
    parameter int pFIFO_DEPTH = 4
) (
    input  logic                            iclk,
    input  logic                            ireset,
    input  logic                            iclkena,
    input  logic [pRADDR_W:0]               irsize,
    input  logic [$clog2(pRDAT_W/pDAT_W):0] irlast,
    input  logic                            irfull,
    input  logic [pRDAT_W-1:0]              irdat,
    input  logic [pTAG_W-1:0]               irtag,
    output logic                            orempty,
    output logic [pRADDR_W-1:0]             oraddr,
    input  logic                            iabort,
    input  logic                            iready,
    output logic                            ofull,
    output logic                            osop,
    output logic                            oeop,
    output logic                            oval,
    output logic [pDAT_W-1:0]               odat,
    output logic [pTAG_W-1:0]               otag
);
    localparam int F  = pRDAT_W / pDAT_W;
    localparam int LW = $clog2(F) + 1;
    localparam int PW = $clog2(pFIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;
    state_e state_q, state_d;

    logic [pRADDR_W:0]   size_q;
    logic [LW-1:0]       last_q;
    logic [pTAG_W-1:0]   tag_q;
    logic [pRADDR_W-1:0] addr_q;
    logic                v1_q, v2_q;

    logic [pRDAT_W-1:0]  fifo_mem [pFIFO_DEPTH];
    logic [PW-1:0]       wptr_q, rptr_q;
    logic [PW:0]         cnt_q;
    logic [PW+1:0]       occ;

    logic [pRDAT_W-1:0]  sr_q, sr_shift;
    logic [LW-1:0]       lanes_q;
    logic                sr_last_q, first_q;
    logic [pRADDR_W:0]   ld_cnt_q;

    logic start, abort, accept, last_beat, issue, last_issue, load, ld_is_last;

    always_comb begin
        start      = (state_q == StIdle) && irfull;
        abort      = (state_q != StIdle) && iabort;
        accept     = oval && iready;
        last_beat  = accept && oeop;
        // Credit check: words held plus reads still in the 2-cycle buffer pipeline.
        occ        = (PW+2)'(cnt_q) + (PW+2)'(v1_q) + (PW+2)'(v2_q);
        issue      = (state_q == StRead) && !iabort && (occ < (PW+2)'(pFIFO_DEPTH));
        last_issue = issue && ({1'b0, addr_q} == size_q - 1'b1);
        load       = (cnt_q != '0) && ((lanes_q == '0) || (accept && lanes_q == LW'(1)));
        ld_is_last = (ld_cnt_q == size_q - 1'b1);
    end

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            state_q <= StIdle;
        end else if (iclkena) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (irfull) state_d = StRead;
            StRead: begin
                if (iabort)          state_d = StIdle;
                else if (last_issue) state_d = StDrain;
            end
            StDrain: if (iabort || last_beat) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ofull   = (state_q != StIdle);
        orempty = iclkena && (abort || ((state_q == StDrain) && last_beat));
    end

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            size_q <= '0;
            last_q <= '0;
            tag_q  <= '0;
            addr_q <= '0;
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
        end else if (iclkena) begin
            if (start) begin
                size_q <= irsize;
                last_q <= irlast;
                tag_q  <= irtag;
                addr_q <= '0;
            end else if (issue && !last_issue) begin
                addr_q <= addr_q + 1'b1;
            end
            v1_q <= issue;
            v2_q <= v1_q && !abort;
        end
    end

    always_ff @(posedge iclk) begin
        if (iclkena && v2_q) begin
            fifo_mem[wptr_q] <= irdat;
        end
    end

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (iclkena) begin
            if (abort) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
            end else begin
                if (v2_q) wptr_q <= wptr_q + 1'b1;
                if (load) rptr_q <= rptr_q + 1'b1;
                cnt_q <= cnt_q + (PW+1)'(v2_q) - (PW+1)'(load);
            end
        end
    end

`ifdef LDPC_DVB_ENC_SINK_AXS_MSB_FIRST_EN
    assign odat     = sr_q[pRDAT_W-1 -: pDAT_W];
    assign sr_shift = sr_q << pDAT_W;
`else
    assign odat     = sr_q[pDAT_W-1:0];
    assign sr_shift = sr_q >> pDAT_W;
`endif

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            sr_q      <= '0;
            lanes_q   <= '0;
            sr_last_q <= 1'b0;
            first_q   <= 1'b0;
            ld_cnt_q  <= '0;
        end else if (iclkena) begin
            if (start) begin
                ld_cnt_q <= '0;
                first_q  <= 1'b1;
            end else if (accept) begin
                first_q  <= 1'b0;
            end
            if (abort) begin
                lanes_q   <= '0;
                sr_last_q <= 1'b0;
            end else if (load) begin
                sr_q      <= fifo_mem[rptr_q];
                lanes_q   <= ld_is_last ? last_q : LW'(F);
                sr_last_q <= ld_is_last;
                ld_cnt_q  <= ld_cnt_q + 1'b1;
            end else if (accept) begin
                sr_q    <= sr_shift;
                lanes_q <= lanes_q - 1'b1;
            end
        end
    end

    assign oval   = (lanes_q != '0);
    assign osop   = oval && first_q;
    assign oeop   = oval && sr_last_q && (lanes_q == LW'(1));
    assign otag   = tag_q;
    assign oraddr = addr_q;

endmodule

// File: tb/tb_ldpc_dvb_enc_sink_axs.sv
// Scoreboard bench for ldpc_dvb_enc_sink_axs: a frame-level model queues expected beats and an
// independent monitor compares every accepted beat; directed and random frames, abort and reset.
module tb_ldpc_dvb_enc_sink_axs;
    localparam int RA = 8;
    localparam int RD = 32;
    localparam int DW = 8;
    localparam int TW = 8;
    localparam int FD = 4;
    localparam int F  = RD / DW;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic          sop;
        logic          eop;
        logic [TW-1:0] tag;
    } beat_t;

    logic                iclk = 1'b0;
    logic                ireset = 1'b0;
    logic                iclkena = 1'b1;
    logic [RA:0]         irsize = '0;
    logic [$clog2(F):0]  irlast = '0;
    logic                irfull = 1'b0;
    logic [RD-1:0]       irdat = '0;
    logic [TW-1:0]       irtag = '0;
    logic                iabort = 1'b0;
    logic                iready = 1'b0;
    logic                orempty, ofull, osop, oeop, oval;
    logic [RA-1:0]       oraddr;
    logic [DW-1:0]       odat;
    logic [TW-1:0]       otag;

    logic [RD-1:0] buf_mem [0:(1<<RA)-1];
    logic [RD-1:0] rd1 = '0, rd2 = '0;
    beat_t exp_q[$];
    int n_cmp = 0, n_fail = 0, n_empty = 0, cyc = 0, first_cyc = -1;
    int rdy_mode = 0, pat = 0;
    logic          stall_q = 1'b0;
    logic [DW+2:0] stall_v = '0;

    ldpc_dvb_enc_sink_axs #(
        .pRADDR_W(RA), .pRDAT_W(RD), .pDAT_W(DW), .pTAG_W(TW), .pFIFO_DEPTH(FD)
    ) dut (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .irsize(irsize), .irlast(irlast),
        .irfull(irfull), .irdat(irdat), .irtag(irtag), .orempty(orempty), .oraddr(oraddr),
        .iabort(iabort), .iready(iready), .ofull(ofull), .osop(osop), .oeop(oeop),
        .oval(oval), .odat(odat), .otag(otag)
    );

    always #5 iclk = ~iclk;

    initial forever begin
        @(posedge iclk);
        cyc++;
    end

    // Buffer model: data for the address shown in cycle t is on irdat in cycle t+2.
    initial forever begin
        @(posedge iclk);
        #1;
        irdat = rd2;
        rd2 = rd1;
        rd1 = buf_mem[oraddr];
    end

    initial forever begin
        @(posedge iclk);
        #1;
        case (rdy_mode)
            0: iready = 1'b1;
            1: begin
                if (oval) begin
                    iready = (pat < 4) ? (pat % 2 == 0) : (pat >= 14);
                    pat++;
                end else begin
                    iready = 1'b0;
                end
            end
            default: iready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected beat per accepted beat and checks stall stability.
    initial forever begin
        beat_t e;
        @(negedge iclk);
        if (!ireset) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) check("stall_hold", {oval, odat, osop, oeop}, stall_v);
            if (oval && osop && first_cyc < 0) first_cyc = cyc;
            if (orempty) n_empty++;
            if (oval && iready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_beat: got dat=%h sop=%b eop=%b, expected no beat",
                             odat, osop, oeop);
                end else begin
                    e = exp_q.pop_front();
                    if ({odat, osop, oeop, otag} !== e) begin
                        n_fail++;
                        $display("FAIL beat: got dat=%h sop=%b eop=%b tag=%h expected dat=%h sop=%b eop=%b tag=%h",
                                 odat, osop, oeop, otag, e.dat, e.sop, e.eop, e.tag);
                    end
                end
            end
            stall_q = oval && !iready;
            stall_v = {oval, odat, osop, oeop};
        end
    end

    task automatic load_frame(input int size, input int last, input logic [TW-1:0] tag,
                              input bit fixed);
        beat_t b;
        logic [RD-1:0] w;
        for (int i = 0; i < size; i++) begin
            for (int k = 0; k < F; k++) w[DW*k +: DW] = fixed ? DW'(F*i + k) : DW'($urandom);
            buf_mem[i] = w;
        end
        for (int i = 0; i < size; i++) begin
            int n;
            n = (i == size - 1) ? last : F;
            w = buf_mem[i];
            for (int j = 0; j < n; j++) begin
                int lane;
`ifdef LDPC_DVB_ENC_SINK_AXS_MSB_FIRST_EN
                lane = F - 1 - j;
`else
                lane = j;
`endif
                b.dat = w[DW*lane +: DW];
                b.sop = (i == 0) && (j == 0);
                b.eop = (i == size - 1) && (j == n - 1);
                b.tag = tag;
                exp_q.push_back(b);
            end
        end
        irsize = (RA+1)'(size);
        irlast = ($clog2(F)+1)'(last);
        irtag = tag;
        irfull = 1'b1;
        first_cyc = -1;
    endtask

    task automatic wait_empty(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge iclk);
            if (orempty) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout: no orempty within %0d cycles", budget);
        end
    endtask

    task automatic run_frame(input int size, input int last, input logic [TW-1:0] tag,
                             input bit fixed);
        int s, e0;
        bit ok;
        @(posedge iclk);
        #1;
        e0 = n_empty;
        load_frame(size, last, tag, fixed);
        s = cyc;
        wait_empty(400, ok);
        irfull = 1'b0;
        if (ok) check("raddr_end", oraddr, size - 1);
        check("latency", first_cyc - s, 5);
        @(negedge iclk);
        #1;
        check("orempty_pulses", n_empty - e0, 1);
        check("ofull_clear", ofull, 0);
    endtask

    initial begin
        int s2, e0;
        bit ok;
        for (int i = 0; i < (1 << RA); i++) buf_mem[i] = '0;
        #12;
        check("rst_oval", oval, 0);
        check("rst_flags", {osop, oeop, ofull, orempty}, 0);
        check("rst_oraddr", oraddr, 0);
        check("rst_otag", otag, 0);
        #5 ireset = 1'b1;

        // Normal frame, then the same frame under backpressure.
        rdy_mode = 0;
        run_frame(3, 4, 8'h11, 1'b1);
        rdy_mode = 1;
        pat = 0;
        run_frame(3, 4, 8'h22, 1'b1);

        rdy_mode = 0;
        run_frame(2, 1, 8'h33, 1'b1);
        run_frame(1, 1, 8'h44, 1'b1);

        // Back-to-back with irfull held high.
        @(posedge iclk);
        #1;
        e0 = n_empty;
        load_frame(3, 4, 8'hA5, 1'b0);
        wait_empty(400, ok);
        load_frame(4, 2, 8'h5A, 1'b0);
        s2 = cyc + 1;
        @(negedge iclk);
        check("b2b_idle_gap", ofull, 0);
        @(negedge iclk);
        check("b2b_restart", ofull, 1);
        wait_empty(400, ok);
        irfull = 1'b0;
        #1;
        check("b2b_orempty_pulses", n_empty - e0, 2);
        check("b2b_latency", first_cyc - s2, 5);

        rdy_mode = 2;
        for (int f = 0; f < 12; f++) begin
            run_frame($urandom_range(1, 8), $urandom_range(1, F), TW'($urandom), 1'b0);
        end

        // Abort during the third beat.
        rdy_mode = 0;
        @(posedge iclk);
        #1;
        load_frame(3, 4, 8'h3C, 1'b0);
        repeat (7) begin
            @(posedge iclk);
            #1;
        end
        iabort = 1'b1;
        @(negedge iclk);
        check("abort_beat3_valid", oval, 1);
        check("abort_orempty", orempty, 1);
        @(posedge iclk);
        #1;
        iabort = 1'b0;
        irfull = 1'b0;
        @(negedge iclk);
        check("abort_oval_drop", oval, 0);
        check("abort_ofull_clear", ofull, 0);
        #1;
        check("abort_beats_dropped", exp_q.size(), 9);
        exp_q.delete();
        run_frame(3, 4, 8'h66, 1'b1);

        // Asynchronous reset in the middle of a frame.
        @(posedge iclk);
        #1;
        load_frame(3, 4, 8'h77, 1'b1);
        repeat (6) @(posedge iclk);
        #3;
        ireset = 1'b0;
        #1;
        check("arst_oval", oval, 0);
        check("arst_flags", {osop, oeop, ofull, orempty}, 0);
        check("arst_oraddr", oraddr, 0);
        check("arst_otag", otag, 0);
        exp_q.delete();
        irfull = 1'b0;
        repeat (2) @(posedge iclk);
        #2;
        ireset = 1'b1;
        run_frame(3, 4, 8'h88, 1'b1);

        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
